// File: rtl/elevator_scheduler.sv
// Single-car SCAN elevator controller: latches floor calls, times travel and door dwell.
// Optional DOOR_HOLD_EN: when defined, door_hold freezes the door dwell timer.
module elevator_scheduler #(
  parameter int NUM_FLOORS    = 10,
  parameter int FLOOR_WIDTH   = 4,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_FLOORS-1:0]  floor_call,
  input  logic                   door_hold,
  output logic [FLOOR_WIDTH-1:0] current_floor,
  output logic                   dir_up,
  output logic                   moving,
  output logic                   door_open,
  output logic [NUM_FLOORS-1:0]  pending_requests,
  output logic [1:0]             state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  localparam int TIMER_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
  localparam logic [TIMER_W-1:0]     TRAVEL_LAST = TIMER_W'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0]     DOOR_LAST   = TIMER_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_WIDTH-1:0] TOP_FLOOR   = FLOOR_WIDTH'(NUM_FLOORS - 1);

  function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [FLOOR_WIDTH-1:0] flr);
    return {{(NUM_FLOORS-1){1'b0}}, 1'b1} << flr;
  endfunction

  function automatic logic any_above(input logic [NUM_FLOORS-1:0] req,
                                     input logic [FLOOR_WIDTH-1:0] flr);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      hit = hit | (req[i] & (FLOOR_WIDTH'(i) > flr));
    end
    return hit;
  endfunction

  function automatic logic any_below(input logic [NUM_FLOORS-1:0] req,
                                     input logic [FLOOR_WIDTH-1:0] flr);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      hit = hit | (req[i] & (FLOOR_WIDTH'(i) < flr));
    end
    return hit;
  endfunction

  state_t                 state_r, next_state_s;
  logic [FLOOR_WIDTH-1:0] floor_r, next_floor_s, step_floor_s;
  logic [TIMER_W-1:0]     timer_r, next_timer_s;
  logic [NUM_FLOORS-1:0]  pending_r, clear_mask_s, cur_mask_s, step_mask_s;
  logic                   dir_up_r, next_dir_s, moving_r, door_open_r;
  logic                   here_s, above_s, below_s, step_hit_s, beyond_s;
  logic                   call_here_s, at_edge_s, hold_s;

  assign cur_mask_s   = floor_mask(floor_r);
  assign here_s       = |(pending_r & cur_mask_s);
  assign above_s      = any_above(pending_r, floor_r);
  assign below_s      = any_below(pending_r, floor_r);
  assign call_here_s  = |(floor_call & cur_mask_s);
  assign step_floor_s = (state_r == MOVE_DOWN) ? floor_r - FLOOR_WIDTH'(1'b1)
                                               : floor_r + FLOOR_WIDTH'(1'b1);
  assign step_mask_s  = floor_mask(step_floor_s);
  assign step_hit_s   = |(pending_r & step_mask_s);
  assign beyond_s     = (state_r == MOVE_DOWN) ? any_below(pending_r, step_floor_s)
                                               : any_above(pending_r, step_floor_s);
  // Guards the shaft ends even though moves are only entered toward a request.
  assign at_edge_s    = (state_r == MOVE_DOWN) ? (floor_r == '0) : (floor_r == TOP_FLOOR);

`ifdef DOOR_HOLD_EN
  assign hold_s = door_hold;
`else
  logic unused_door_hold_s;
  assign unused_door_hold_s = door_hold;
  assign hold_s = 1'b0;
`endif

  // Next-state, next-floor, direction, timer and request-clear decisions.
  always_comb begin
    next_state_s = state_r;
    next_floor_s = floor_r;
    next_dir_s   = dir_up_r;
    next_timer_s = timer_r;
    clear_mask_s = '0;
    case (state_r)
      IDLE: begin
        next_timer_s = '0;
        if (here_s) begin
          next_state_s = DOOR_OPEN;
          clear_mask_s = cur_mask_s;
        end else if (above_s && (dir_up_r || !below_s)) begin
          next_state_s = MOVE_UP;
          next_dir_s   = 1'b1;
        end else if (below_s) begin
          next_state_s = MOVE_DOWN;
          next_dir_s   = 1'b0;
        end else begin
          next_state_s = IDLE;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (timer_r != TRAVEL_LAST) begin
          next_timer_s = timer_r + TIMER_W'(1'b1);
        end else if (at_edge_s) begin
          next_timer_s = '0;
          next_state_s = IDLE;
        end else begin
          next_timer_s = '0;
          next_floor_s = step_floor_s;
          if (step_hit_s) begin
            next_state_s = DOOR_OPEN;
            clear_mask_s = step_mask_s;
          end else if (beyond_s) begin
            next_state_s = state_r;
          end else begin
            next_state_s = IDLE;
          end
        end
      end
      DOOR_OPEN: begin
        if (call_here_s) begin
          next_timer_s = '0;
          clear_mask_s = cur_mask_s;
        end else if (hold_s) begin
          next_timer_s = timer_r;
        end else if (timer_r != DOOR_LAST) begin
          next_timer_s = timer_r + TIMER_W'(1'b1);
        end else begin
          next_timer_s = '0;
          if (dir_up_r ? above_s : below_s) begin
            next_state_s = dir_up_r ? MOVE_UP : MOVE_DOWN;
          end else if (dir_up_r ? below_s : above_s) begin
            next_state_s = dir_up_r ? MOVE_DOWN : MOVE_UP;
            next_dir_s   = ~dir_up_r;
          end else begin
            next_state_s = IDLE;
          end
        end
      end
      default: begin
        next_state_s = IDLE;
        next_timer_s = '0;
      end
    endcase
  end

  // Car state, request latch and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      floor_r     <= '0;
      dir_up_r    <= 1'b1;
      timer_r     <= '0;
      pending_r   <= '0;
      moving_r    <= 1'b0;
      door_open_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      floor_r     <= next_floor_s;
      dir_up_r    <= next_dir_s;
      timer_r     <= next_timer_s;
      pending_r   <= (pending_r | floor_call) & ~clear_mask_s;
      moving_r    <= (next_state_s == MOVE_UP) || (next_state_s == MOVE_DOWN);
      door_open_r <= (next_state_s == DOOR_OPEN);
    end
  end

  assign current_floor    = floor_r;
  assign dir_up           = dir_up_r;
  assign moving           = moving_r;
  assign door_open        = door_open_r;
  assign pending_requests = pending_r;
  assign state            = state_r;

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Single-car elevator controller. It latches floor call pulses into a pending-request register and schedules car motion with a SCAN policy: keep moving in the current direction while requests remain ahead, then reverse. It times floor-to-floor travel and door dwell, and it drives the car floor, direction, motion and door outputs. It sits above the combinational above/below request detection and owns all sequencing of the car.

## Interface
- `NUM_FLOORS`, default 10: number of floors, indexed 0..NUM_FLOORS-1.
- `FLOOR_WIDTH`, default 4: width of floor index; must satisfy 2^FLOOR_WIDTH >= NUM_FLOORS.
- `TRAVEL_CYCLES`, default 4: clock cycles to move one floor; must be >= 1.
- `DOOR_CYCLES`, default 3: clock cycles the door stays open; must be >= 1.

Ports:
- `clk`, input, 1: the only clock; all state changes on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `floor_call`, input, NUM_FLOORS: call pulses, one bit per floor; any bit high in a cycle is latched.
- `door_hold`, input, 1: extends the door dwell; only meaningful when DOOR_HOLD_EN is defined.
- `current_floor`, output, FLOOR_WIDTH: registered car position.
- `dir_up`, output, 1: current or last travel direction; 1 = up.
- `moving`, output, 1: high in MOVE_UP and MOVE_DOWN.
- `door_open`, output, 1: high in DOOR_OPEN.
- `pending_requests`, output, NUM_FLOORS: latched unserved requests.
- `state`, output, 2: IDLE=0, MOVE_UP=1, MOVE_DOWN=2, DOOR_OPEN=3.

## Operation
- Reset values:
  - state IDLE, current_floor 0, dir_up 1.
  - moving 0, door_open 0, pending_requests 0.
  - Internal timer 0.
- Request latch:
  - Each edge, `pending_requests <= (pending_requests | floor_call) & ~clear_mask`.
  - `clear_mask` is the one-hot bit of the floor being served on that edge. Clear beats set for that bit.
- Derived flags, computed combinationally from the registered `pending_requests` and `current_floor`:
  - `here` = bit at current_floor.
  - `above` = any bit with index > current_floor.
  - `below` = any bit with index < current_floor.
- IDLE:
  - If `here`: go to DOOR_OPEN and clear that bit.
  - Else, with `dir_up` = 1: `above` takes MOVE_UP, else `below` takes MOVE_DOWN.
  - Else, with `dir_up` = 0: `below` takes MOVE_DOWN, else `above` takes MOVE_UP.
  - `dir_up` updates to match the chosen move.
  - Otherwise stay in IDLE.
- MOVE_UP / MOVE_DOWN:
  - The timer counts 0..TRAVEL_CYCLES-1.
  - At the terminal count, current_floor steps by ±1 and the timer resets to 0.
  - On that same edge, if the request bit of the new floor is set: go to DOOR_OPEN and clear that bit.
  - Otherwise continue if requests remain beyond the new floor in the travel direction; else go to IDLE.
  - The floor never moves below 0 or above NUM_FLOORS-1. A move is only entered when a request exists in that direction.
- DOOR_OPEN:
  - The timer counts 0..DOOR_CYCLES-1.
  - A `floor_call` for current_floor while the door is open is cleared the same edge and reloads the timer to 0. This reopen behaviour continues the dwell.
  - At the terminal count, continue in `dir_up` direction if requests exist there; else reverse if requests exist the other way (flipping `dir_up`); else go to IDLE.
- Simultaneous calls on many floors are all latched in one edge.
- Reset asserted mid-travel or mid-dwell returns everything to reset values on that edge. Pending calls are discarded.

## Timing
- A call pulse sampled at edge N is visible in `pending_requests` after edge N.
- The car leaves IDLE at edge N+1.
- Travel from IDLE to a request k floors away: the floor changes every TRAVEL_CYCLES edges after leaving IDLE, and `door_open` rises on the same edge the floor reaches the target.
- `door_open` stays high for exactly DOOR_CYCLES cycles, absent reopen or hold.
- `moving` and `door_open` are never high together.
- All outputs are registered. There is no combinational input-to-output path.

## Configuration
- `DOOR_HOLD_EN`, defined: while `door_hold` = 1 in DOOR_OPEN, the timer holds its value and the door stays open indefinitely. The dwell resumes counting when `door_hold` drops.
- `DOOR_HOLD_EN`, undefined: `door_hold` is ignored, and dwell is strictly DOOR_CYCLES cycles (plus reopens).

## Test plan
Parameters for all scenarios: NUM_FLOORS=10, TRAVEL_CYCLES=4, DOOR_CYCLES=3; call pulsed in cycle 0.
- **Reset:** after `rst` → state 0, floor 0, dir_up 1, pending 0, door_open 0.
- **Single call:** floor_call[3] at floor 0 → pending bit 3 after edge 1; MOVE_UP from edge 2; floor 1/2/3 at edges 6/10/14. door_open is high cycles 14–16, then IDLE at edge 17 with pending 0.
- **SCAN ordering:** car at floor 5 moving up, with pending bits 2 and 8 → serves 8 first, then reverses (dir_up 0) and serves 2.
- **Call at current floor:** call at current floor while IDLE → door_open after edge 2, with no motion. The same call during DOOR_OPEN → dwell restarts and door_open lasts 3 cycles from the reload.
- **Mid-travel reset:** `rst` asserted during MOVE_UP between floors 2 and 3 → floor 0, IDLE, pending 0 the following cycle.
- **DOOR_HOLD_EN:** with the macro defined, `door_hold` high for 10 cycles → door_open stays high for 10 + 3 cycles. With the macro undefined, door_open is high for exactly 3 cycles.
